// File: rtl/ai_i2s_wb_arbiter_if.sv
// Bus bundle between two Wishbone requesters (CPU, DMA), the arbiter and the
// shared I2S core port. Signal names follow the arbiter's pin names.
interface ai_i2s_wb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // Requester 0 (CPU)
  logic                  m0_cyc_i;
  logic                  m0_stb_i;
  logic                  m0_we_i;
  logic [ADDR_WIDTH-1:0] m0_adr_i;
  logic [DATA_WIDTH-1:0] m0_dat_i;
  logic                  m0_sel_i;
  logic [2:0]            m0_cti_i;
  logic [1:0]            m0_bte_i;
  logic                  m0_is_tx_i;
  logic                  m0_ack_o;
  logic                  m0_err_o;
  logic [DATA_WIDTH-1:0] m0_dat_o;

  // Requester 1 (DMA)
  logic                  m1_cyc_i;
  logic                  m1_stb_i;
  logic                  m1_we_i;
  logic [ADDR_WIDTH-1:0] m1_adr_i;
  logic [DATA_WIDTH-1:0] m1_dat_i;
  logic                  m1_sel_i;
  logic [2:0]            m1_cti_i;
  logic [1:0]            m1_bte_i;
  logic                  m1_is_tx_i;
  logic                  m1_ack_o;
  logic                  m1_err_o;
  logic [DATA_WIDTH-1:0] m1_dat_o;

  // Shared port towards the I2S core
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic [ADDR_WIDTH-1:0] s_adr_o;
  logic [DATA_WIDTH-1:0] s_dat_o;
  logic                  s_sel_o;
  logic [2:0]            s_cti_o;
  logic [1:0]            s_bte_o;
  logic                  s_is_tx_o;
  logic                  s_ack_i;
  logic [DATA_WIDTH-1:0] s_dat_i;

  // One-hot current owner
  logic [1:0]            grant_o;

  // Arbiter view
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m0_sel_i, m0_cti_i, m0_bte_i, m0_is_tx_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  m1_sel_i, m1_cti_i, m1_bte_i, m1_is_tx_i,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output s_sel_o, s_cti_o, s_bte_o, s_is_tx_o,
    input  s_ack_i, s_dat_i,
    output grant_o
  );

  // Environment view (requesters and core together)
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m0_sel_i, m0_cti_i, m0_bte_i, m0_is_tx_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output m1_sel_i, m1_cti_i, m1_bte_i, m1_is_tx_i,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  s_sel_o, s_cti_o, s_bte_o, s_is_tx_o,
    output s_ack_i, s_dat_i,
    input  grant_o
  );

endinterface

// File: rtl/ai_i2s_wb_arbiter.sv
// Two-requester round-robin Wishbone arbiter in front of the I2S core
// register port, with an ack watchdog that terminates stalled cycles.
module ai_i2s_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  ai_i2s_wb_arbiter_if.slave    bus
);

  localparam int unsigned CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                  busy_c;
  logic                  err_c;
  logic                  own_cyc_c;
  logic                  own_stb_c;
  logic                  own_we_c;
  logic [ADDR_WIDTH-1:0] own_adr_c;
  logic [DATA_WIDTH-1:0] own_dat_c;
  logic                  own_sel_c;
  logic [2:0]            own_cti_c;
  logic [1:0]            own_bte_c;
  logic                  own_is_tx_c;

  assign busy_c = (state_q == ST_BUSY);
  assign err_c  = (state_q == ST_ERR);

  // Select the current owner's request signals
  always_comb begin
    own_cyc_c   = bus.m0_cyc_i;
    own_stb_c   = bus.m0_stb_i;
    own_we_c    = bus.m0_we_i;
    own_adr_c   = bus.m0_adr_i;
    own_dat_c   = bus.m0_dat_i;
    own_sel_c   = bus.m0_sel_i;
    own_cti_c   = bus.m0_cti_i;
    own_bte_c   = bus.m0_bte_i;
    own_is_tx_c = bus.m0_is_tx_i;
    if (owner_q) begin
      own_cyc_c   = bus.m1_cyc_i;
      own_stb_c   = bus.m1_stb_i;
      own_we_c    = bus.m1_we_i;
      own_adr_c   = bus.m1_adr_i;
      own_dat_c   = bus.m1_dat_i;
      own_sel_c   = bus.m1_sel_i;
      own_cti_c   = bus.m1_cti_i;
      own_bte_c   = bus.m1_bte_i;
      own_is_tx_c = bus.m1_is_tx_i;
    end
  end

  // Shared port: owner's request passed through only while BUSY
  always_comb begin
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_adr_o   = '0;
    bus.s_dat_o   = '0;
    bus.s_sel_o   = 1'b0;
    bus.s_cti_o   = 3'b000;
    bus.s_bte_o   = 2'b00;
    bus.s_is_tx_o = 1'b0;
    if (busy_c) begin
      bus.s_cyc_o   = own_cyc_c;
      bus.s_stb_o   = own_stb_c;
      bus.s_we_o    = own_we_c;
      bus.s_adr_o   = own_adr_c;
      bus.s_dat_o   = own_dat_c;
      bus.s_sel_o   = own_sel_c;
      bus.s_cti_o   = own_cti_c;
      bus.s_bte_o   = own_bte_c;
      bus.s_is_tx_o = own_is_tx_c;
    end
  end

  // Return path: ack/data to the owner in BUSY, err to the owner in ERR
  always_comb begin
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_dat_o = '0;
    if (busy_c) begin
      if (owner_q) begin
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_dat_o = bus.s_dat_i;
      end else begin
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_dat_o = bus.s_dat_i;
      end
    end
    if (err_c) begin
      if (owner_q) begin
        bus.m1_err_o = 1'b1;
      end else begin
        bus.m0_err_o = 1'b1;
      end
    end
  end

  // One-hot grant whenever a cycle is in progress
  always_comb begin
    bus.grant_o = 2'b00;
    if (busy_c || err_c) begin
      bus.grant_o = owner_q ? 2'b10 : 2'b01;
    end
  end

  // Next-state, ownership and watchdog logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.m0_cyc_i || bus.m1_cyc_i) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          if (bus.m0_cyc_i && bus.m1_cyc_i) begin
            owner_d = ~last_owner_q;
          end else begin
            owner_d = bus.m1_cyc_i;
          end
        end
      end
      ST_BUSY: begin
        if (!own_cyc_c) begin
          state_d      = ST_IDLE;
          last_owner_d = owner_q;
          cnt_d        = '0;
        end else if (bus.s_ack_i) begin
          // A late ack still beats the watchdog
          cnt_d = '0;
        end else if (own_stb_c) begin
          if (cnt_q == CNT_LIMIT) begin
            state_d = ST_ERR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_ERR: begin
        state_d      = ST_IDLE;
        last_owner_d = owner_q;
        cnt_d        = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; last_owner resets to 1 so requester 0 wins first contention
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ai_i2s_wb_arbiter.sv
// Directed bench for ai_i2s_wb_arbiter with TIMEOUT = 8.
module tb_ai_i2s_wb_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ai_i2s_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ai_i2s_wb_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_adr_i = '0;
    bus.m0_dat_i = '0; bus.m0_sel_i = 0; bus.m0_cti_i = 3'b000; bus.m0_bte_i = 2'b00;
    bus.m0_is_tx_i = 0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_adr_i = '0;
    bus.m1_dat_i = '0; bus.m1_sel_i = 0; bus.m1_cti_i = 3'b000; bus.m1_bte_i = 2'b00;
    bus.m1_is_tx_i = 0;
    bus.s_ack_i = 0; bus.s_dat_i = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();

    // Reset values
    settle();
    chk("rst_grant", bus.grant_o, 2'b00);
    chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
    chk("rst_m0_err", bus.m0_err_o, 1'b0);
    rst_n = 1'b1;

    // Simultaneous requests: m0 wins first contention
    tick();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    settle();
    chk("rr_idle_grant", bus.grant_o, 2'b00);
    tick();
    chk("rr_first_grant", bus.grant_o, 2'b01);
    chk("rr_s_cyc", bus.s_cyc_o, 1'b1);
    bus.s_ack_i = 1; bus.s_dat_i = 32'h0000_1234;
    settle();
    chk("rr_m0_ack", bus.m0_ack_o, 1'b1);
    chk("rr_m0_dat", bus.m0_dat_o, 32'h0000_1234);
    chk("rr_m1_ack", bus.m1_ack_o, 1'b0);
    chk("rr_m1_dat", bus.m1_dat_o, 32'h0);
    tick();
    bus.s_ack_i = 0; bus.s_dat_i = '0;
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    settle();
    chk("rr_drop_s_cyc", bus.s_cyc_o, 1'b0);
    tick();
    chk("rr_gap_grant", bus.grant_o, 2'b00);
    tick();
    chk("rr_second_grant", bus.grant_o, 2'b10);

    // m1 write to TX bank
    bus.m1_we_i = 1; bus.m1_adr_i = 32'h04; bus.m1_dat_i = 32'hDEAD_BEEF;
    bus.m1_is_tx_i = 1; bus.m1_sel_i = 1;
    settle();
    chk("wr_s_adr", bus.s_adr_o, 32'h04);
    chk("wr_s_dat", bus.s_dat_o, 32'hDEAD_BEEF);
    chk("wr_s_is_tx", bus.s_is_tx_o, 1'b1);
    chk("wr_s_we", bus.s_we_o, 1'b1);
    bus.s_ack_i = 1;
    settle();
    chk("wr_m1_ack", bus.m1_ack_o, 1'b1);
    chk("wr_m0_ack", bus.m0_ack_o, 1'b0);
    tick();
    bus.s_ack_i = 0;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    settle();
    chk("wr_m1_ack_end", bus.m1_ack_o, 1'b0);
    tick();
    clear_inputs();
    settle();
    chk("wr_idle_grant", bus.grant_o, 2'b00);

    // m0 4-beat burst while m1 waits
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_cti_i = 3'b010;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    tick();
    chk("bu_grant", bus.grant_o, 2'b01);
    for (int i = 0; i < 4; i++) begin
      bus.m0_cti_i = (i == 3) ? 3'b111 : 3'b010;
      bus.s_ack_i  = 1;
      settle();
      chk("bu_m0_ack", bus.m0_ack_o, 1'b1);
      chk("bu_m1_ack", bus.m1_ack_o, 1'b0);
      chk("bu_s_cti", bus.s_cti_o, (i == 3) ? 3'b111 : 3'b010);
      chk("bu_hold_grant", bus.grant_o, 2'b01);
      tick();
    end
    bus.s_ack_i = 0;
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_cti_i = 3'b000;
    settle();
    chk("bu_drop_grant", bus.grant_o, 2'b01);
    tick();
    chk("bu_gap_grant", bus.grant_o, 2'b00);
    tick();
    chk("bu_m1_grant", bus.grant_o, 2'b10);
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    tick();
    chk("bu_end_grant", bus.grant_o, 2'b00);

    // Watchdog: 8 unacked BUSY cycles then one ERR cycle
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    tick();
    chk("to_grant", bus.grant_o, 2'b01);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_wait_err", bus.m0_err_o, 1'b0);
      chk("to_wait_s_cyc", bus.s_cyc_o, 1'b1);
    end
    tick();
    chk("to_m0_err", bus.m0_err_o, 1'b1);
    chk("to_m1_err", bus.m1_err_o, 1'b0);
    chk("to_s_cyc", bus.s_cyc_o, 1'b0);
    chk("to_s_stb", bus.s_stb_o, 1'b0);
    chk("to_err_grant", bus.grant_o, 2'b01);
    tick();
    chk("to_err_pulse", bus.m0_err_o, 1'b0);
    chk("to_idle_grant", bus.grant_o, 2'b00);
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    tick();

    // Ack on the last waiting cycle beats the watchdog
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    tick();
    chk("la_grant", bus.grant_o, 2'b01);
    for (int i = 1; i < 8; i++) tick();
    bus.s_ack_i = 1;
    settle();
    chk("la_m0_ack", bus.m0_ack_o, 1'b1);
    chk("la_m0_err", bus.m0_err_o, 1'b0);
    tick();
    bus.s_ack_i = 0;
    settle();
    chk("la_no_err", bus.m0_err_o, 1'b0);
    chk("la_still_busy", bus.s_cyc_o, 1'b1);
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    tick();
    chk("la_idle_grant", bus.grant_o, 2'b00);

    // Reset mid-transfer, then fresh arbitration favours m0
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 32'h10; bus.m1_cti_i = 3'b010;
    tick();
    chk("rs_m1_grant", bus.grant_o, 2'b10);
    bus.s_ack_i = 1; bus.s_dat_i = 32'h5555_AAAA;
    settle();
    chk("rs_m1_ack_pre", bus.m1_ack_o, 1'b1);
    rst_n = 1'b0;
    settle();
    chk("rs_grant", bus.grant_o, 2'b00);
    chk("rs_m1_ack", bus.m1_ack_o, 1'b0);
    chk("rs_m1_dat", bus.m1_dat_o, 32'h0);
    chk("rs_s_cyc", bus.s_cyc_o, 1'b0);
    chk("rs_s_adr", bus.s_adr_o, 32'h0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    tick();
    chk("rs_first_grant", bus.grant_o, 2'b01);
    clear_inputs();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
